// File: rtl/cmp_bist_sequencer_if.sv
// Comparator-side bus of the BIST sequencer: operands out, flags back.
// master = sequencer (drives a_out/b_out), slave = comparator (drives flags).
interface cmp_bist_sequencer_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             gt_in;
    logic             eq_in;
    logic             lt_in;

    modport master (
        output a_out,
        output b_out,
        input  gt_in,
        input  eq_in,
        input  lt_in
    );

    modport slave (
        input  a_out,
        input  b_out,
        output gt_in,
        output eq_in,
        output lt_in
    );
endinterface

// File: rtl/cmp_bist_sequencer.sv
// BIST sequencer: sweeps all {A,B} pairs into a magnitude comparator,
// samples its gt/eq/lt flags after SETTLE_CYCLES and checks them.
// Ports: clk, rst (sync, active-high), start, cmp (master bus),
// busy, done, pass, fail_count, illegal_seen, first_fail_a/b/valid.
module cmp_bist_sequencer #(
    parameter int WIDTH         = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    cmp_bist_sequencer_if.master cmp,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     fail_count,
    output logic                 illegal_seen,
    output logic [WIDTH-1:0]     first_fail_a,
    output logic [WIDTH-1:0]     first_fail_b,
    output logic                 first_fail_valid
);
    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam int CW =
        (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] MAX = '1;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [2*WIDTH:0]    fc_q, fc_d;
    logic                ill_q, ill_d;
    logic [WIDTH-1:0]    ffa_q, ffa_d;
    logic [WIDTH-1:0]    ffb_q, ffb_d;
    logic                ffv_q, ffv_d;

    logic [2:0]          flags;
    logic [2:0]          golden;
    logic                mism;

    assign flags  = {cmp.gt_in, cmp.eq_in, cmp.lt_in};
    assign golden = {a_q > b_q, a_q == b_q, a_q < b_q};
    // golden is always one-hot, so a non-one-hot flag set
    // is automatically a mismatch as well.
    assign mism   = (flags != golden);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            fc_q    <= '0;
            ill_q   <= 1'b0;
            ffa_q   <= '0;
            ffb_q   <= '0;
            ffv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fc_q    <= fc_d;
            ill_q   <= ill_d;
            ffa_q   <= ffa_d;
            ffb_q   <= ffb_d;
            ffv_q   <= ffv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        fc_d    = fc_q;
        ill_d   = ill_q;
        ffa_d   = ffa_q;
        ffb_d   = ffb_q;
        ffv_d   = ffv_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                    a_d     = '0;
                    b_d     = '0;
                    fc_d    = '0;
                    ill_d   = 1'b0;
                    ffa_d   = '0;
                    ffb_d   = '0;
                    ffv_d   = 1'b0;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CHECK: begin
                if (mism) begin
                    fc_d = fc_q + 1'b1;
                    if (!ffv_q) begin
                        ffa_d = a_q;
                        ffb_d = b_q;
                        ffv_d = 1'b1;
                    end
                end
                if (!$onehot(flags)) begin
                    ill_d = 1'b1;
                end
                if (a_q == MAX && b_q == MAX) begin
                    state_d = DONE;
                end else begin
                    state_d = SETTLE;
                    b_d     = b_q + 1'b1;
                    if (b_q == MAX) begin
                        a_d = a_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy             = (state_q == SETTLE) || (state_q == CHECK);
        done             = (state_q == DONE);
        pass             = done && (fc_q == '0);
        fail_count       = fc_q;
        illegal_seen     = ill_q;
        first_fail_a     = ffa_q;
        first_fail_b     = ffb_q;
        first_fail_valid = ffv_q;
        cmp.a_out        = a_q;
        cmp.b_out        = b_q;
    end
endmodule

// File: tb/tb_cmp_bist_sequencer.sv
// Scoreboard bench for cmp_bist_sequencer: two instances (settle 1 and 3)
// driven by a behavioural comparator with selectable faults.
module tb_cmp_bist_sequencer;
    localparam int W = 2;

    typedef struct {
        int inst;
        int t0;
        int n;
        int fc;
        int ill;
        int ffv;
        int ffa;
        int ffb;
        int pass;
    } exp_t;

    exp_t       sq[$];
    logic [3:0] pq[$];
    int         npass = 0;
    int         ntot  = 0;
    int         cyc   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst[2];
    logic start[2];
    int   fault[2];
    bit   wrong[2];
    bit   hold_chk;

    logic         busy_s[2];
    logic         done_s[2];
    logic         pass_s[2];
    logic         ill_s[2];
    logic         ffv_s[2];
    logic [2*W:0] fc_s[2];
    logic [W-1:0] a_s[2];
    logic [W-1:0] b_s[2];
    logic [W-1:0] ffa_s[2];
    logic [W-1:0] ffb_s[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int S = (g == 0) ? 1 : 3;
        logic gt, eq, lt;
        cmp_bist_sequencer_if #(.WIDTH(W)) bus ();
        cmp_bist_sequencer #(
            .WIDTH(W),
            .SETTLE_CYCLES(S)
        ) dut (
            .clk(clk),
            .rst(rst[g]),
            .start(start[g]),
            .cmp(bus.master),
            .busy(busy_s[g]),
            .done(done_s[g]),
            .pass(pass_s[g]),
            .fail_count(fc_s[g]),
            .illegal_seen(ill_s[g]),
            .first_fail_a(ffa_s[g]),
            .first_fail_b(ffb_s[g]),
            .first_fail_valid(ffv_s[g])
        );
        assign a_s[g] = bus.a_out;
        assign b_s[g] = bus.b_out;
        always_comb begin
            gt = bus.a_out > bus.b_out;
            eq = bus.a_out == bus.b_out;
            lt = bus.a_out < bus.b_out;
            if (fault[g] == 1) gt = 1'b0;
            if (fault[g] == 2) eq = 1'b1;
            if (wrong[g]) begin
                gt = !gt;
                eq = !eq;
                lt = !lt;
            end
            bus.gt_in = gt;
            bus.eq_in = eq;
            bus.lt_in = lt;
        end
    end

    task automatic check(string nm, int got, int exp);
        ntot++;
        if (got == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    // Monitor: pops expected pairs on every new operand pair and
    // expected sweep results whenever done rises.
    bit         was_busy[2];
    bit         was_done[2];
    logic [3:0] last[2];
    int         hold[2];
    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] ep;
        int         s;
        for (int i = 0; i < 2; i++) begin
            s = (i == 0) ? 1 : 3;
            if (busy_s[i]) begin
                if (!was_busy[i] || {a_s[i], b_s[i]} != last[i]) begin
                    if (was_busy[i] && hold_chk)
                        check("pair_hold", hold[i], s + 1);
                    hold[i] = 1;
                    if (pq.size() > 0) begin
                        ep = pq.pop_front();
                        check("pair_order", {a_s[i], b_s[i]}, ep);
                    end
                end else begin
                    hold[i]++;
                end
            end else if (was_busy[i] && hold_chk) begin
                check("pair_hold_last", hold[i], s + 1);
            end
            if (done_s[i] && !was_done[i]) begin
                if (sq.size() == 0) begin
                    ntot++;
                    $display("FAIL done_unexpected: inst %0d at cycle %0d",
                             i, cyc);
                end else begin
                    e = sq.pop_front();
                    check("done_inst", i, e.inst);
                    check("done_latency", cyc - e.t0, e.n);
                    check("fail_count", fc_s[i], e.fc);
                    check("illegal_seen", ill_s[i], e.ill);
                    check("ff_valid", ffv_s[i], e.ffv);
                    check("ff_a", ffa_s[i], e.ffa);
                    check("ff_b", ffb_s[i], e.ffb);
                    check("pass", pass_s[i], e.pass);
                    check("busy_at_done", busy_s[i], 0);
                end
            end
            was_busy[i] = busy_s[i];
            was_done[i] = done_s[i];
            last[i]     = {a_s[i], b_s[i]};
        end
    end

    // Called on a negedge: queues the expected results, pulses start.
    task automatic push_sweep(int i, int fc, int ill, int ffv,
                              int ffa, int ffb);
        exp_t e;
        logic [3:0] p;
        e.inst = i;
        e.t0   = cyc + 1;
        e.n    = 16 * ((i == 0) ? 2 : 4);
        e.fc   = fc;
        e.ill  = ill;
        e.ffv  = ffv;
        e.ffa  = ffa;
        e.ffb  = ffb;
        e.pass = (fc == 0) ? 1 : 0;
        sq.push_back(e);
        for (int k = 0; k < 16; k++) begin
            p = 4'(k);
            pq.push_back(p);
        end
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic wait_done(int i, int limit);
        int n = 0;
        while (!done_s[i] && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!done_s[i]) begin
            ntot++;
            $display("FAIL wait_done: inst %0d timed out after %0d", i, n);
        end
    endtask

    task automatic check_clear(int i, string tag);
        check({tag, "_busy"}, busy_s[i], 0);
        check({tag, "_done"}, done_s[i], 0);
        check({tag, "_pass"}, pass_s[i], 0);
        check({tag, "_fc"}, fc_s[i], 0);
        check({tag, "_ill"}, ill_s[i], 0);
        check({tag, "_ffv"}, ffv_s[i], 0);
        check({tag, "_a"}, a_s[i], 0);
        check({tag, "_b"}, b_s[i], 0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i]   = 1'b1;
            start[i] = 1'b0;
            fault[i] = 0;
            wrong[i] = 1'b0;
        end
        hold_chk = 1'b0;
        repeat (3) @(negedge clk);
        check_clear(0, "reset0");
        check_clear(1, "reset1");
        check("reset0_ffa", ffa_s[0], 0);
        check("reset0_ffb", ffb_s[0], 0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);

        // ideal comparator
        hold_chk = 1'b1;
        push_sweep(0, 0, 0, 0, 0, 0);
        wait_done(0, 40);

        // gt stuck low: 6 A>B pairs read all-zero flags
        fault[0] = 1;
        push_sweep(0, 6, 1, 1, 1, 0);
        wait_done(0, 40);

        // eq stuck high: 12 unequal pairs read two hot flags
        fault[0] = 2;
        push_sweep(0, 12, 1, 1, 0, 1);
        wait_done(0, 40);

        // start mid-sweep ignored, then restart from DONE clears results
        fault[0] = 1;
        push_sweep(0, 6, 1, 1, 1, 0);
        repeat (9) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, 40);
        fault[0] = 0;
        push_sweep(0, 0, 0, 0, 0, 0);
        check("restart_busy", busy_s[0], 1);
        check("restart_done", done_s[0], 0);
        check("restart_fc", fc_s[0], 0);
        check("restart_ill", ill_s[0], 0);
        check("restart_ffv", ffv_s[0], 0);
        wait_done(0, 40);

        // reset mid-sweep drops all partial results
        hold_chk = 1'b0;
        fault[0] = 2;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (9) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check_clear(0, "midrst");
        fault[0] = 0;
        @(negedge clk);
        hold_chk = 1'b1;
        push_sweep(0, 0, 0, 0, 0, 0);
        wait_done(0, 40);

        // settle 3: flags garbage except in the CHECK cycle of each pair
        push_sweep(1, 0, 0, 0, 0, 0);
        for (int j = 0; j < 64; j++) begin
            wrong[1] = (j % 4 != 3);
            @(negedge clk);
        end
        wrong[1] = 1'b0;
        wait_done(1, 8);

        repeat (2) @(negedge clk);
        check("sb_results_drained", sq.size(), 0);
        check("sb_pairs_drained", pq.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/cmp_bist_sequencer.md
Name: cmp_bist_sequencer

Overview:
- Built-in self-test stage wrapped around the 2-bit magnitude comparator.
- Sweeps every operand pair {A,B} into the comparator's inputs and samples its gt/eq/lt flags after a programmable settle time.
- Checks the flags against an internal golden compare and reports the pass/fail summary to the top-level outputs.
- Sits directly upstream of the comparator and also consumes its result flags.

Parameters:
- WIDTH, 2: operand width in bits. The sweep covers 2^(2*WIDTH) pairs.
- SETTLE_CYCLES, 1: cycles each pair is held before its flags are sampled. Must be >= 1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  level-sampled request to begin a sweep
- a_out  out  WIDTH  operand A driven to the comparator
- b_out  out  WIDTH  operand B driven to the comparator
- gt_in  in  1  comparator flag A>B
- eq_in  in  1  comparator flag A==B
- lt_in  in  1  comparator flag A<B
- busy  out  1  sweep in progress
- done  out  1  sweep finished; held until the next accepted start or rst
- pass  out  1  done && fail_count==0
- fail_count  out  2*WIDTH+1  number of mismatching pairs
- illegal_seen  out  1  sticky: a sampled flag set was not one-hot
- first_fail_a  out  WIDTH  A of the first mismatching pair
- first_fail_b  out  WIDTH  B of the first mismatching pair
- first_fail_valid  out  1  first_fail_a/b hold a valid capture

Behaviour:
- Interface: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE; settle counter 0.
- rst takes priority over every other input. If asserted mid-sweep, all state returns to reset values at that edge and no partial results are kept.
- FSM has four states: IDLE, SETTLE, CHECK, DONE.
- IDLE: when start=1, the next edge sets a_out=0, b_out=0, busy=1 and enters SETTLE. This edge also clears fail_count, illegal_seen, first_fail_* and done.
- SETTLE: the settle counter increments every cycle. When counter==SETTLE_CYCLES-1, the next edge resets the counter and enters CHECK. Operands stay stable throughout.
- CHECK: the flags are sampled at the CHECK edge.
  - Expected flags are {A>B, A==B, A<B}, unsigned compare of a_out vs b_out.
  - Mismatch means {gt_in,eq_in,lt_in} differs from expected in any bit.
  - On mismatch, fail_count increments. If first_fail_valid=0, it also captures a_out/b_out and sets first_fail_valid.
  - If the flags are not exactly one-hot, illegal_seen sets. A non-one-hot set always also counts as a mismatch.
- Operand advance, also at the CHECK edge:
  - b_out increments; A is the outer loop and B the inner loop.
  - On b_out wrap from max to 0, a_out increments.
  - If the pair was a_out=b_out=max, enter DONE instead: busy=0, done=1, operands hold at max.
  - Otherwise return to SETTLE.
- Latency: each pair takes SETTLE_CYCLES+1 cycles. With start accepted at edge k, done rises at edge k + 2^(2*WIDTH)*(SETTLE_CYCLES+1). Defaults give 32 cycles.
- start while busy is ignored.
- start in DONE begins a new sweep exactly as from IDLE, including clearing results.
- start held continuously re-arms a new sweep every time DONE is reached.
- fail_count width covers the all-fail case (16 at defaults), so no saturation or wrap occurs.
- pass is combinational from done and fail_count and is 0 whenever done=0.
- Flag inputs are ignored outside CHECK.

Test Plan:
- Ideal comparator model on flags, start pulsed 1 cycle:
  - pairs appear in order (0,0),(0,1)…(3,3);
  - done=1 exactly 32 cycles after the start edge;
  - pass=1, fail_count=0, illegal_seen=0, first_fail_valid=0.
- gt_in stuck at 0, others correct:
  - fail_count=6, illegal_seen=1 (flags all-zero on A>B pairs);
  - first_fail_a=1, first_fail_b=0, pass=0.
- eq_in stuck at 1, others correct:
  - fail_count=12, illegal_seen=1;
  - first_fail = (0,1).
- start re-pulsed at cycle 10 of a sweep: ignored, done still at cycle 32. Then start in DONE: results clear, and a second sweep completes 32 cycles later.
- rst asserted at cycle 10 for 1 cycle: next edge busy=0, a_out=b_out=0, fail_count=0, done=0. A later start runs a full clean sweep.
- SETTLE_CYCLES=3, ideal model: each pair is held 4 cycles, done at cycle 64, pass=1. Flags driven wrong except in CHECK cycles give no failures.
